fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter FIFO_DEPTH, default 2, instruction buffer entries (power of two, >=2).
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 imem_req  output  1  fetch request, one-cycle pulse per request.
REQ-006 imem_addr  output  32  word address of request, valid while imem_req=1.
REQ-007 imem_rvalid  input  1  response strobe, arrives >=1 cycle after the request.
REQ-008 imem_rdata  input  32  instruction word, valid with imem_rvalid.
REQ-009 redirect_valid  input  1  branch/JAL/JALR taken, one-cycle pulse.
REQ-010 redirect_pc  input  32  target PC, valid with redirect_valid.
REQ-011 if_valid  output  1  if_instr/if_pc hold a valid instruction.
REQ-012 if_instr  output  32  instruction at FIFO head.
REQ-013 if_pc  output  32  PC of if_instr.
REQ-014 id_ready  input  1  decode accepts head this cycle.
REQ-015 if_misalign  output  1  head-entry misaligned-fetch flag (present only with FETCH_MISALIGN_EN).

Function
REQ-016 FSM states IDLE, REQ, WAIT; at most one outstanding request.
REQ-017 IDLE->REQ when FIFO occupancy < FIFO_DEPTH; otherwise stay IDLE.
REQ-018 REQ: imem_req=1, imem_addr=fetch_pc for exactly one cycle, then ->WAIT.
REQ-019 WAIT: on imem_rvalid push {fetch_pc, imem_rdata}, fetch_pc <= fetch_pc+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0), ->REQ if a slot is free after push/pop, else ->IDLE.
REQ-020 Latency: pushed entry visible at if_valid the cycle after imem_rvalid when the FIFO was empty.
REQ-021 Pop when if_valid && id_ready; if_instr/if_pc stay stable while if_valid && !id_ready.
REQ-022 Simultaneous push and pop in one cycle keeps occupancy unchanged; pop of empty FIFO is impossible (if_valid=0).
REQ-023 Redirect has priority over push, pop and request: FIFO flushed same edge, fetch_pc <= redirect_pc, if_valid=0 next cycle.
REQ-024 Redirect while in WAIT sets kill; the pending response is dropped and kill clears on it, then a request to redirect_pc is issued.
REQ-025 Redirect in IDLE/REQ: state ->REQ next cycle with fetch_pc=redirect_pc; a request pulsed in the redirect cycle is treated as killed.
REQ-026 imem_rvalid with no outstanding request is ignored.

Reset
REQ-027 reset=0 asynchronously forces state=IDLE, fetch_pc=RESET_PC, FIFO empty, kill=0, imem_req=0, if_valid=0, if_instr=0, if_pc=0, if_misalign=0.
REQ-028 Reset mid-WAIT abandons the request; first request after release goes to RESET_PC.

Configuration
REQ-029 Macro FETCH_MISALIGN_EN: when defined, a redirect_pc with [1:0]!=0 pushes one entry {redirect_pc, 32'h0000_0013} with if_misalign=1 without a memory request, then FSM holds IDLE until next redirect.
REQ-030 Without FETCH_MISALIGN_EN: port if_misalign absent, redirect_pc[1:0] forced to 0.

Structure
REQ-031 Package fetch_pkg holds fetch state enum, entry struct {pc, instr, misalign}, NOP constant 32'h0000_0013.
REQ-032 Sub-module fetch_fifo (synchronous FIFO with flush, full/empty, count) is instantiated once.

Verification
REQ-033 Reset release, memory latency 1, id_ready=1 -> requests to 0x0,0x4,0x8; if_pc sequence 0x0,0x4,0x8 each one cycle after rvalid.
REQ-034 id_ready=0 for 10 cycles -> two entries buffered, imem_req stays 0, head holds if_pc=0x0 unchanged.
REQ-035 Redirect to 0x100 while WAIT on 0x8, latency 3 -> 0x8 response dropped, next if_pc=0x100.
REQ-036 Redirect to 0xFFFF_FFFC -> if_pc 0xFFFF_FFFC then 0x0000_0000.
REQ-037 reset asserted during WAIT -> if_valid=0 immediately, late rvalid ignored, first new request to RESET_PC.
REQ-038 FETCH_MISALIGN_EN, redirect to 0x102 -> if_misalign=1, if_instr=0x00000013, if_pc=0x102, no imem_req.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Holds the fetch FSM state encoding, the instruction-buffer entry layout and the NOP word.
// No logic here; it is imported by fetch_fifo and fetch_unit.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        misalign;
    } fetch_entry_t;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Sequential fetch address; wraps from 32'hFFFF_FFFC to 0.
    function automatic logic [31:0] pc_next(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: synchronous FIFO of fetch entries with a single-cycle flush.
// Latency: a pushed entry is visible at head the cycle after the push edge.
// Backpressure: caller must only push when !full (or when popping); flush empties the
//   buffer and may accept a push on the same edge, which becomes the new head.
// Ports: clk, reset (async active-low), flush, push/push_data, pop, head, full, empty, count.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    output fetch_entry_t head,
    output logic         full,
    output logic         empty,
    output logic [AW:0]  count
);

    fetch_entry_t    mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   wr_idx;
    logic [AW:0]     cnt;
    logic            do_push;
    logic            do_pop;

    assign empty  = (cnt == '0);
    assign full   = (cnt == (AW+1)'(DEPTH));
    assign count  = cnt;
    assign head   = mem[rd_ptr];

    // Flush discards the old contents, so pop is meaningless on that edge and a
    // push always has room (it lands in slot 0).
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && (flush || !full || do_pop);
    assign wr_idx  = flush ? '0 : wr_ptr;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_idx] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= AW'(do_push);
            cnt    <= (AW+1)'(do_push);
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one-outstanding-request memory fetcher feeding a small instruction buffer.
// Latency: a response is visible at if_valid the cycle after imem_rvalid when the buffer was empty.
// Backpressure: decode stalls via id_ready; no new request is issued while the buffer has no free slot.
// Ports: clk/reset (async active-low); imem_req/imem_addr out, imem_rvalid/imem_rdata in;
//   redirect_valid/redirect_pc in; if_valid/if_instr/if_pc out, id_ready in;
//   if_misalign out only when FETCH_MISALIGN_EN is defined.
// Optional feature macro FETCH_MISALIGN_EN: a misaligned redirect target produces a single NOP
//   entry flagged misaligned and halts fetching until the next redirect. Without it, redirect
//   targets are forced to word alignment.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        id_ready
`ifdef FETCH_MISALIGN_EN
    ,
    output logic        if_misalign
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t  state;
    fetch_state_t  state_nxt;
    logic [31:0]   fetch_pc;
    logic [31:0]   fetch_pc_nxt;
    logic          kill;
    logic          kill_nxt;
    logic          halt;
    logic          halt_nxt;

    logic          fifo_flush;
    logic          fifo_push;
    logic          fifo_pop;
    fetch_entry_t  push_entry;
    fetch_entry_t  fifo_head;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;

    logic [31:0]   redir_pc;
    logic          redir_misalign;
    logic          slot_free_after;
    logic          resp_pending;

`ifdef FETCH_MISALIGN_EN
    assign redir_pc       = redirect_pc;
    assign redir_misalign = |redirect_pc[1:0];
`else
    assign redir_pc       = redirect_pc & 32'hFFFF_FFFC;
    assign redir_misalign = 1'b0;
`endif

    assign fifo_pop = if_valid && id_ready;

    // After this cycle's push (and possible pop) is there still room for another response?
    assign slot_free_after = (fifo_count < CW'(FIFO_DEPTH - 1)) || fifo_pop;

    // A request is in flight whose response has not arrived this cycle; a redirect now
    // must leave a kill marker so that response is dropped later.
    assign resp_pending = (state == WAIT) && !imem_rvalid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            kill     <= 1'b0;
            halt     <= 1'b0;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            kill     <= kill_nxt;
            halt     <= halt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        kill_nxt     = kill;
        halt_nxt     = halt;
        fifo_flush   = 1'b0;
        fifo_push    = 1'b0;
        push_entry   = '{pc: fetch_pc, instr: imem_rdata, misalign: 1'b0};
        imem_req     = 1'b0;

        unique case (state)
            IDLE: begin
                if (!halt && !fifo_full) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                imem_req  = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (imem_rvalid) begin
                    if (kill) begin
                        // Stale response from before a redirect: drop it and fetch the new target.
                        kill_nxt  = 1'b0;
                        state_nxt = halt ? IDLE : REQ;
                    end else begin
                        fifo_push    = 1'b1;
                        fetch_pc_nxt = pc_next(fetch_pc);
                        state_nxt    = slot_free_after ? REQ : IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Redirect overrides everything above. The request is suppressed in the redirect
        // cycle so the memory never sees a request for the abandoned path from REQ.
        if (redirect_valid) begin
            fifo_flush   = 1'b1;
            fifo_push    = 1'b0;
            imem_req     = 1'b0;
            fetch_pc_nxt = redir_pc;
            halt_nxt     = redir_misalign;
            if (resp_pending) begin
                kill_nxt  = 1'b1;
                state_nxt = WAIT;
            end else begin
                // Either no request is in flight or its response is arriving now and is discarded.
                kill_nxt  = 1'b0;
                state_nxt = redir_misalign ? IDLE : REQ;
            end
            if (redir_misalign) begin
                fifo_push  = 1'b1;
                push_entry = '{pc: redir_pc, instr: NOP_INSTR, misalign: 1'b1};
            end
        end
    end

    assign imem_addr = fetch_pc;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (fifo_flush),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Outputs read as zero when the buffer is empty so stale slots never leak out.
    assign if_valid = !fifo_empty;
    assign if_instr = if_valid ? fifo_head.instr : '0;
    assign if_pc    = if_valid ? fifo_head.pc    : '0;

`ifdef FETCH_MISALIGN_EN
    assign if_misalign = if_valid && fifo_head.misalign;
`else
    logic unused_head_misalign;
    assign unused_head_misalign = fifo_head.misalign;
`endif

endmodule
